// File: rtl/difftest_commit_tracker_pkg.sv
// Shared definitions for the Difftest commit tracker.
// Holds the trap opcode default, the tracker state encoding and the field widths.
package difftest_commit_tracker_pkg;

  localparam logic [6:0] TRAP_OP_DEFAULT = 7'h6b;
  localparam int         REG_IDX_W       = 5;
  localparam int         WDEST_W         = 8;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_TRAPPED = 2'd1,
    ST_HUNG    = 2'd2
  } state_e;

endpackage

// File: rtl/difftest_commit_tracker_if.sv
// Retire-side and Difftest-side signal bundle of the commit tracker.
// The master side drives retire information; the slave side is the tracker.
interface difftest_commit_tracker_if #(
  parameter int NCOMMIT = 2,
  parameter int XLEN    = 64
);
  import difftest_commit_tracker_pkg::*;

  logic [NCOMMIT-1:0]           in_valid;
  logic [NCOMMIT*XLEN-1:0]      in_pc;
  logic [NCOMMIT*32-1:0]        in_inst;
  logic [NCOMMIT-1:0]           in_wen;
  logic [NCOMMIT*REG_IDX_W-1:0] in_wdest;
  logic [NCOMMIT*XLEN-1:0]      in_wdata;
  logic [XLEN-1:0]              a0_value;

  logic [NCOMMIT-1:0]           cmt_valid;
  logic [NCOMMIT*XLEN-1:0]      cmt_pc;
  logic [NCOMMIT*32-1:0]        cmt_inst;
  logic [NCOMMIT-1:0]           cmt_wen;
  logic [NCOMMIT*WDEST_W-1:0]   cmt_wdest;
  logic [NCOMMIT*XLEN-1:0]      cmt_wdata;
  logic                         trap_valid;
  logic [7:0]                   trap_code;
  logic [XLEN-1:0]              trap_pc;
  logic [63:0]                  cycle_cnt;
  logic [63:0]                  instr_cnt;
  logic                         timeout;

  modport master (
    output in_valid, in_pc, in_inst, in_wen, in_wdest, in_wdata, a0_value,
    input  cmt_valid, cmt_pc, cmt_inst, cmt_wen, cmt_wdest, cmt_wdata,
    input  trap_valid, trap_code, trap_pc, cycle_cnt, instr_cnt, timeout
  );

  modport slave (
    input  in_valid, in_pc, in_inst, in_wen, in_wdest, in_wdata, a0_value,
    output cmt_valid, cmt_pc, cmt_inst, cmt_wen, cmt_wdest, cmt_wdata,
    output trap_valid, trap_code, trap_pc, cycle_cnt, instr_cnt, timeout
  );

endinterface

// File: rtl/difftest_commit_tracker_popcount.sv
// Combinational population count of the effective commit mask.
module difftest_commit_tracker_popcount
  import difftest_commit_tracker_pkg::*;
#(
  parameter int NCOMMIT = 2,
  localparam int CNT_W  = $clog2(NCOMMIT + 1)
) (
  input  logic [NCOMMIT-1:0] i_bits,
  output logic [CNT_W-1:0]   o_count
);

  // Sum the set bits of the commit mask.
  always_comb begin
    o_count = '0;
    for (int k = 0; k < NCOMMIT; k++) begin
      o_count = o_count + CNT_W'(i_bits[k]);
    end
  end

endmodule

// File: rtl/difftest_commit_tracker.sv
// Commit-side tracker feeding the Difftest InstrCommit/TrapEvent modules.
// Registers up to NCOMMIT retirements per cycle, counts cycles and instructions,
// stops at the first trap opcode in program order and reports a hung core.
module difftest_commit_tracker
  import difftest_commit_tracker_pkg::*;
#(
  parameter int         NCOMMIT = 2,
  parameter int         XLEN    = 64,
  parameter int         TIMEOUT = 5000,
  parameter logic [6:0] TRAP_OP = TRAP_OP_DEFAULT
) (
  input logic                 clock,
  input logic                 reset,
  difftest_commit_tracker_if.slave bus
);

  localparam int CNT_W = $clog2(NCOMMIT + 1);
  localparam int IDX_W = (NCOMMIT > 1) ? $clog2(NCOMMIT) : 1;
  localparam int WD_W  = $clog2(TIMEOUT);

  state_e                     r_state;
  state_e                     w_state_nxt;
  logic                       w_run;

  logic                       w_trap_hit;
  logic [IDX_W-1:0]           w_trap_idx;
  logic [XLEN-1:0]            w_trap_pc;
  logic [NCOMMIT-1:0]         w_eff_valid;
  logic [NCOMMIT-1:0]         w_cmt_wen;
  logic [NCOMMIT*WDEST_W-1:0] w_wdest_ext;
  logic [CNT_W-1:0]           w_pop;
  logic                       w_any;
  logic                       w_wd_expire;

  logic [NCOMMIT-1:0]         r_cmt_valid;
  logic [NCOMMIT*XLEN-1:0]    r_cmt_pc;
  logic [NCOMMIT*32-1:0]      r_cmt_inst;
  logic [NCOMMIT-1:0]         r_cmt_wen;
  logic [NCOMMIT*WDEST_W-1:0] r_cmt_wdest;
  logic [NCOMMIT*XLEN-1:0]    r_cmt_wdata;
  logic                       r_trap_valid;
  logic [7:0]                 r_trap_code;
  logic [XLEN-1:0]            r_trap_pc;
  logic [63:0]                r_cycle_cnt;
  logic [63:0]                r_instr_cnt;
  logic                       r_timeout;
  logic [WD_W-1:0]            r_wd;

  // Only the low byte of a0 forms the trap code.
  logic w_unused;
  assign w_unused = ^bus.a0_value[XLEN-1:8];

  // Pick the oldest channel carrying the trap opcode, and its PC.
  always_comb begin
    w_trap_hit = 1'b0;
    w_trap_idx = '0;
    w_trap_pc  = '0;
    for (int k = NCOMMIT - 1; k >= 0; k--) begin
      if (bus.in_valid[k] && (bus.in_inst[k*32 +: 7] == TRAP_OP)) begin
        w_trap_hit = 1'b1;
        w_trap_idx = IDX_W'(k);
        w_trap_pc  = bus.in_pc[k*XLEN +: XLEN];
      end
    end
  end

  // Drop commits younger than the trap; x0 writes never count as writes.
  always_comb begin
    w_eff_valid = '0;
    w_cmt_wen   = '0;
    w_wdest_ext = '0;
    for (int k = 0; k < NCOMMIT; k++) begin
      w_eff_valid[k] = bus.in_valid[k] && (!w_trap_hit || (IDX_W'(k) <= w_trap_idx));
      w_cmt_wen[k]   = bus.in_wen[k] && w_eff_valid[k] &&
                       (bus.in_wdest[k*REG_IDX_W +: REG_IDX_W] != '0);
      w_wdest_ext[k*WDEST_W +: WDEST_W] =
        {{(WDEST_W - REG_IDX_W){1'b0}}, bus.in_wdest[k*REG_IDX_W +: REG_IDX_W]};
    end
  end

  difftest_commit_tracker_popcount #(
    .NCOMMIT (NCOMMIT)
  ) u_popcount (
    .i_bits  (w_eff_valid),
    .o_count (w_pop)
  );

  assign w_any       = |w_eff_valid;
  assign w_wd_expire = !w_any && (r_wd == WD_W'(TIMEOUT - 1));

  // Next state: a trap beats the watchdog; both end states are terminal.
  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_run = 1'b1;
        if (w_trap_hit) begin
          w_state_nxt = ST_TRAPPED;
        end else if (w_wd_expire) begin
          w_state_nxt = ST_HUNG;
        end
      end
      default: w_state_nxt = r_state;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Register the commit channels; once stopped only valid/wen are cleared.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cmt_valid <= '0;
      r_cmt_pc    <= '0;
      r_cmt_inst  <= '0;
      r_cmt_wen   <= '0;
      r_cmt_wdest <= '0;
      r_cmt_wdata <= '0;
    end else if (w_run) begin
      r_cmt_valid <= w_eff_valid;
      r_cmt_pc    <= bus.in_pc;
      r_cmt_inst  <= bus.in_inst;
      r_cmt_wen   <= w_cmt_wen;
      r_cmt_wdest <= w_wdest_ext;
      r_cmt_wdata <= bus.in_wdata;
    end else begin
      r_cmt_valid <= '0;
      r_cmt_wen   <= '0;
    end
  end

  // Free-running cycle and instruction counters, frozen once stopped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else if (w_run) begin
      r_cycle_cnt <= r_cycle_cnt + 64'd1;
      r_instr_cnt <= r_instr_cnt + 64'(w_pop);
    end
  end

  // Latch the trap report on the trapping cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_trap_valid <= 1'b0;
      r_trap_code  <= '0;
      r_trap_pc    <= '0;
    end else if (w_run && w_trap_hit) begin
      r_trap_valid <= 1'b1;
      r_trap_code  <= bus.a0_value[7:0];
      r_trap_pc    <= w_trap_pc;
    end
  end

  // No-commit watchdog: cleared by any commit, fires after TIMEOUT idle cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else if (w_run) begin
      if (w_any) begin
        r_wd <= '0;
      end else if (w_wd_expire) begin
        r_timeout <= 1'b1;
      end else begin
        r_wd <= r_wd + 1'b1;
      end
    end
  end

  assign bus.cmt_valid  = r_cmt_valid;
  assign bus.cmt_pc     = r_cmt_pc;
  assign bus.cmt_inst   = r_cmt_inst;
  assign bus.cmt_wen    = r_cmt_wen;
  assign bus.cmt_wdest  = r_cmt_wdest;
  assign bus.cmt_wdata  = r_cmt_wdata;
  assign bus.trap_valid = r_trap_valid;
  assign bus.trap_code  = r_trap_code;
  assign bus.trap_pc    = r_trap_pc;
  assign bus.cycle_cnt  = r_cycle_cnt;
  assign bus.instr_cnt  = r_instr_cnt;
  assign bus.timeout    = r_timeout;

endmodule

// File: doc/difftest_commit_tracker.md
Name: difftest_commit_tracker

Overview:
- Parametrised commit-side tracker between the core's retire point and the Difftest DPI modules (InstrCommit ×N, TrapEvent).
- Registers up to NCOMMIT retiring instructions per cycle and keeps cycle and instruction counters.
- Detects the 0x6b trap opcode in program order, suppresses younger same-cycle commits, then freezes all state.
- Adds a no-commit watchdog so a hung core is reported rather than simulated indefinitely.

Parameters:
- NCOMMIT, 2, commit channels per cycle (1..4); channel 0 is oldest.
- XLEN, 64, data and PC width.
- TIMEOUT, 5000, consecutive cycles without any valid commit before timeout fires (≥2).
- TRAP_OP, 7'h6b, inst[6:0] value that signals a simulation trap.

Ports:
- clock  in  1  core clock
- reset  in  1  asynchronous active-high reset
- in_valid  in  NCOMMIT  per-channel retire valid
- in_pc  in  NCOMMIT*XLEN  packed PC, channel k at [k*XLEN +: XLEN]
- in_inst  in  NCOMMIT*32  packed instruction words
- in_wen  in  NCOMMIT  register-write enable
- in_wdest  in  NCOMMIT*5  destination register index
- in_wdata  in  NCOMMIT*XLEN  write-back data
- a0_value  in  XLEN  architectural x10 after this cycle's writes
- cmt_valid  out  NCOMMIT  registered commit valid
- cmt_pc  out  NCOMMIT*XLEN  registered PC
- cmt_inst  out  NCOMMIT*32  registered instruction
- cmt_wen  out  NCOMMIT  registered write enable
- cmt_wdest  out  NCOMMIT*8  zero-extended destination
- cmt_wdata  out  NCOMMIT*XLEN  registered write data
- trap_valid  out  1  sticky trap flag
- trap_code  out  8  a0_value[7:0] at the trap cycle
- trap_pc  out  XLEN  PC of the trapping instruction
- cycle_cnt  out  64  cycles since reset, frozen at trap
- instr_cnt  out  64  committed instructions, frozen at trap
- timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (async, any time, including mid-run): every output is 0; the watchdog counter is 0; the next rising edge after release starts normal operation.
- All outputs are registered on the rising edge of clock; latency from in_* to cmt_* is 1 cycle.
- State machine: RUN -> TRAPPED on a trap detect; RUN -> HUNG when the watchdog expires; TRAPPED and HUNG are terminal until reset.
- Trap detect: t = lowest k with in_valid[k] && in_inst[k][6:0]==TRAP_OP.
- Per-channel gating in RUN: eff_valid[k] = in_valid[k] && (no trap in the cycle || k ≤ t). The trapping instruction itself commits; younger channels in the same cycle are dropped.
- Per-channel capture in RUN:
  - cmt_valid[k] = eff_valid[k]
  - cmt_wen[k] = in_wen[k] && eff_valid[k] && in_wdest[k]≠0
  - cmt_wdest = {3'b0, wdest}
  - pc, inst and wdata are captured unconditionally.
- Counters in RUN: cycle_cnt += 1; instr_cnt += popcount(eff_valid). Both wrap modulo 2^64 with no saturation.
- Trap cycle: trap_valid←1, trap_code←a0_value[7:0], trap_pc←in_pc[t], state←TRAPPED. Counters still update in this cycle, so the trap instruction is counted.
- TRAPPED: all outputs hold their values except cmt_valid and cmt_wen, which are forced to 0 from the next cycle on. All in_* inputs are ignored.
- Watchdog in RUN:
  - Counter is cleared on any eff_valid.
  - Otherwise it increments.
  - When it reaches TIMEOUT-1 while incrementing: timeout←1, state←HUNG.
- HUNG behaves like TRAPPED for cmt_*, cycle_cnt and instr_cnt; trap_valid stays 0.
- Simultaneous trap and watchdog expiry in one cycle: impossible, because a trap implies a commit. A trap always wins.
- in_valid with no set bits and no trap: cmt_valid=0, counters and watchdog advance normally.

Decomposition:
- Shared package (difftest_pkg): TRAP_OP default, the RUN/TRAPPED/HUNG state encoding, and the 8-bit wdest width constant.
- One sub-module, commit_popcount (combinational, parametrised by NCOMMIT).
- Priority trap-index selection stays inline in the top module.

Test Plan:
- Reset then 10 idle cycles -> all cmt_valid=0, cycle_cnt=10, instr_cnt=0, timeout=0.
- NCOMMIT=2, both valid for 3 cycles, ch0 wdest=5 wen=1, ch1 wdest=0 wen=1 -> cmt_wen=2'b01, cmt_wdest[0]=8'h05, instr_cnt=6.
- Same cycle: ch0 trap inst 0x0000006b at pc 0x80000010 with a0_value=0, ch1 valid -> cmt_valid=2'b01, trap_valid=1, trap_code=0, trap_pc=0x80000010; counters then frozen for 20 further cycles.
- ch0 ordinary, ch1 trap with a0_value=0x1FF -> cmt_valid=2'b11, trap_code=8'hFF, instr_cnt increased by 2.
- TIMEOUT=8, commit once then idle -> timeout=1 exactly 8 cycles after the last commit, trap_valid=0; later in_valid ignored.
- Assert reset asynchronously mid-run (between edges) -> every output reads 0 immediately; after release, operation resumes from cycle_cnt=0.
